// File: rtl/keypad_pkg.sv
// Shared keypad types and constants: key/code widths, the key event record
// and key indices in scanner bit order (bit 15 = row 0 / column 3).
package keypad_pkg;

    localparam int KEY_W   = 16;
    localparam int CODE_W  = 4;
    localparam int EVENT_W = CODE_W + 1;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              press;
    } key_event_t;

    localparam logic [CODE_W-1:0] KEY_0 = 4'd0;
    localparam logic [CODE_W-1:0] KEY_1 = 4'd1;
    localparam logic [CODE_W-1:0] KEY_2 = 4'd2;
    localparam logic [CODE_W-1:0] KEY_3 = 4'd3;
    localparam logic [CODE_W-1:0] KEY_4 = 4'd4;
    localparam logic [CODE_W-1:0] KEY_5 = 4'd5;
    localparam logic [CODE_W-1:0] KEY_6 = 4'd6;
    localparam logic [CODE_W-1:0] KEY_7 = 4'd7;
    localparam logic [CODE_W-1:0] KEY_8 = 4'd8;
    localparam logic [CODE_W-1:0] KEY_9 = 4'd9;
    localparam logic [CODE_W-1:0] KEY_A = 4'd10;
    localparam logic [CODE_W-1:0] KEY_B = 4'd11;
    localparam logic [CODE_W-1:0] KEY_C = 4'd12;
    localparam logic [CODE_W-1:0] KEY_D = 4'd13;
    localparam logic [CODE_W-1:0] KEY_E = 4'd14;
    localparam logic [CODE_W-1:0] KEY_F = 4'd15;

endpackage

// File: rtl/keypad_event_fifo.sv
// Synchronous show-ahead FIFO for key events; the head word is read straight
// from the storage registers and forced to zero while the FIFO is empty.
module keypad_event_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only; validity is tracked by count, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/keypad_event.sv
// Debounces the scanner key bitmap and turns committed presses (and releases
// when KEYPAD_EVENT_RELEASE_EN is defined) into queued key-code events.
module keypad_event
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [KEY_W-1:0]              key,
    input  logic                          change,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [CODE_W-1:0]             ev_code,
    output logic                          ev_press,
    output logic [KEY_W-1:0]              stable_key,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    function automatic logic [CODE_W-1:0] lowest_index(input logic [KEY_W-1:0] m);
        lowest_index = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (m[i]) lowest_index = CODE_W'(i);
        end
    endfunction

    logic [KEY_W-1:0]   cand;
    logic [CNT_W-1:0]   cnt;
    logic [KEY_W-1:0]   pend_press;
    logic [KEY_W-1:0]   pend_press_n;
    logic [KEY_W-1:0]   src_mask;
    logic [KEY_W-1:0]   clr_mask;
    logic [CODE_W-1:0]  src_code;
    logic               use_press;
    logic               commit;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    key_event_t         ev_in;
    key_event_t         head;
    logic [EVENT_W-1:0] head_bits;

    // Commit on the edge where the counter reaches DEBOUNCE_CYCLES, so the
    // event lands in the FIFO DEBOUNCE_CYCLES+2 edges after the key settles.
    assign commit = (key == cand) && !change &&
                    (cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) && (cand != stable_key);

`ifdef KEYPAD_EVENT_RELEASE_EN
    logic [KEY_W-1:0] pend_rel;
    logic [KEY_W-1:0] pend_rel_n;

    assign use_press  = |pend_press;
    assign src_mask   = use_press ? pend_press : pend_rel;
    assign pend_rel_n = (pend_rel & ~(use_press ? '0 : clr_mask)) |
                        (commit ? (~cand & stable_key) : '0);
`else
    assign use_press  = 1'b1;
    assign src_mask   = pend_press;
`endif

    assign src_code     = lowest_index(src_mask);
    assign push         = !fifo_full && (|src_mask);
    assign clr_mask     = push ? (KEY_W'(1) << src_code) : '0;
    // Clear before set: a bit re-armed by this cycle's commit survives.
    assign pend_press_n = (pend_press & ~(use_press ? clr_mask : '0)) |
                          (commit ? (cand & ~stable_key) : '0);
    assign ev_in        = '{code: src_code, press: use_press};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= '0;
            cnt        <= '0;
            stable_key <= '0;
            pend_press <= '0;
`ifdef KEYPAD_EVENT_RELEASE_EN
            pend_rel   <= '0;
`endif
        end else begin
            if (key != cand || change) begin
                cand <= key;
                cnt  <= '0;
            end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
                cnt  <= cnt + 1'b1;
            end
            if (commit) stable_key <= cand;
            pend_press <= pend_press_n;
`ifdef KEYPAD_EVENT_RELEASE_EN
            pend_rel   <= pend_rel_n;
`endif
        end
    end

    keypad_event_fifo #(
        .DATA_W (EVENT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (ev_in),
        .pop   (ev_ready),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head     = head_bits;
    assign ev_valid = !fifo_empty;
    assign ev_code  = head.code;
    assign ev_press = head.press;

endmodule

// File: tb/tb_keypad_event.sv
// Bench for keypad_event: directed scenarios plus random key traffic, checked
// against an event-queue model of the debounce/emit rules.
module tb_keypad_event;

    localparam int DC    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] key = '0;
    logic        change = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic        ev_press;
    logic [15:0] stable_key;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    keypad_event #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .change     (change),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_press   (ev_press),
        .stable_key (stable_key),
        .fifo_count (fifo_count)
    );

    int total = 0;
    int passed = 0;

    // Reference state: last seen bitmap and how long it has been steady,
    // the debounced bitmap, pending sets and the queue of delivered events.
    logic [15:0] m_last, m_stable, m_pp, m_pr;
    int          m_run;
    int          q_code[$];
    bit          q_press[$];
    int          log_code[$];
    bit          log_press[$];

    task automatic model_reset();
        m_last = '0; m_stable = '0; m_pp = '0; m_pr = '0; m_run = 0;
        q_code.delete(); q_press.delete();
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [15:0] k, input bit ch, input bit rdy);
        int  qn;
        int  src;
        bit  src_press;
        bit  do_pop;
        qn        = q_code.size();
        do_pop    = rdy && (qn > 0);
        src       = -1;
        src_press = 1'b1;
        if (qn < DEPTH) begin
            src = lowest(m_pp);
`ifdef KEYPAD_EVENT_RELEASE_EN
            if (src < 0) begin
                src = lowest(m_pr);
                src_press = 1'b0;
            end
`endif
        end
        if (src >= 0) begin
            if (src_press) m_pp[src] = 1'b0;
            else           m_pr[src] = 1'b0;
        end
        if (k == m_last && !ch) begin
            if (m_run < DC) m_run++;
        end else begin
            m_last = k;
            m_run  = 0;
        end
        if (m_run >= DC && m_last != m_stable) begin
            m_pp = m_pp | (m_last & ~m_stable);
`ifdef KEYPAD_EVENT_RELEASE_EN
            m_pr = m_pr | (~m_last & m_stable);
`endif
            m_stable = m_last;
        end
        if (do_pop) begin
            void'(q_code.pop_front());
            void'(q_press.pop_front());
        end
        if (src >= 0) begin
            q_code.push_back(src);
            q_press.push_back(src_press);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compare_all(input string ph);
        bit has;
        has = (q_code.size() != 0);
        check({ph, ":ev_valid"},   32'(ev_valid),   32'(has));
        check({ph, ":ev_code"},    32'(ev_code),    has ? 32'(q_code[0]) : 32'd0);
        check({ph, ":ev_press"},   32'(ev_press),   has ? 32'(q_press[0]) : 32'd0);
        check({ph, ":stable_key"}, 32'(stable_key), 32'(m_stable));
        check({ph, ":fifo_count"}, 32'(fifo_count), 32'(q_code.size()));
    endtask

    task automatic tick(input logic [15:0] k, input bit ch, input bit rdy, input string ph);
        key = k; change = ch; ev_ready = rdy;
        if (ev_valid && rdy) begin
            log_code.push_back(int'(ev_code));
            log_press.push_back(ev_press);
        end
        @(posedge clk);
        model_edge(k, ch, rdy);
        #1;
        compare_all(ph);
    endtask

    task automatic hold(input logic [15:0] k, input int n, input bit rdy, input string ph);
        for (int i = 0; i < n; i++) tick(k, 1'b0, rdy, ph);
    endtask

    task automatic clear_log();
        log_code.delete();
        log_press.delete();
    endtask

    initial begin
        logic [15:0] rk;
        int          len;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst:ev_valid",   32'(ev_valid),   32'd0);
        check("rst:ev_code",    32'(ev_code),    32'd0);
        check("rst:ev_press",   32'(ev_press),   32'd0);
        check("rst:stable_key", 32'(stable_key), 32'd0);
        check("rst:fifo_count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;

        // Single press: latency and exactly one event
        clear_log();
        for (int n = 1; n <= 6; n++) begin
            tick(16'h0001, 1'b0, 1'b1, "single");
            if (n == 4) check("single:stable_before", 32'(stable_key), 32'h0);
            if (n == 5) begin
                check("single:stable_commit", 32'(stable_key), 32'h1);
                check("single:valid_early",   32'(ev_valid),   32'd0);
            end
            if (n == 6) begin
                check("single:valid", 32'(ev_valid), 32'd1);
                check("single:code",  32'(ev_code),  32'd0);
                check("single:press", 32'(ev_press), 32'd1);
            end
        end
        hold(16'h0001, 6, 1'b1, "single_hold");
        check("single:count", 32'(log_code.size()), 32'd1);
        hold(16'h0000, 12, 1'b1, "release0");

        // Bouncing key never settles
        clear_log();
        for (int i = 0; i < 20; i++)
            tick(((i / 2) % 2 == 0) ? 16'h0010 : 16'h0000, 1'b0, 1'b1, "bounce");
        check("bounce:stable", 32'(stable_key), 32'h0);
        check("bounce:events", 32'(log_code.size()), 32'd0);
        hold(16'h0000, 6, 1'b1, "bounce_settle");

        // Simultaneous presses come out in ascending order
        clear_log();
        hold(16'h8011, 12, 1'b1, "multi");
        check("multi:count", 32'(log_code.size()), 32'd3);
        if (log_code.size() == 3) begin
            check("multi:code0", 32'(log_code[0]), 32'd0);
            check("multi:code1", 32'(log_code[1]), 32'd4);
            check("multi:code2", 32'(log_code[2]), 32'd15);
        end
        hold(16'h0000, 14, 1'b1, "multi_rel");

        // Full FIFO back-pressure, then drain without loss
        clear_log();
        hold(16'h00FC, 14, 1'b0, "full");
        check("full:fifo_count", 32'(fifo_count), 32'd4);
        hold(16'h00FC, 12, 1'b1, "drain");
        check("drain:count", 32'(log_code.size()), 32'd6);
        for (int i = 0; i < log_code.size() && i < 6; i++)
            check("drain:order", 32'(log_code[i]), 32'(i + 2));
        hold(16'h0000, 16, 1'b1, "drain_rel");

        // Press then release of key 9
        clear_log();
        hold(16'h0200, 10, 1'b1, "k9_press");
        hold(16'h0000, 12, 1'b1, "k9_rel");
        check("k9:first_code",  32'(log_code.size() > 0 ? log_code[0] : -1), 32'd9);
        check("k9:first_press", 32'(log_press.size() > 0 ? log_press[0] : 1'b0), 32'd1);
`ifdef KEYPAD_EVENT_RELEASE_EN
        check("k9:count", 32'(log_code.size()), 32'd2);
        if (log_code.size() == 2) begin
            check("k9:rel_code",  32'(log_code[1]),  32'd9);
            check("k9:rel_press", 32'(log_press[1]), 32'd0);
        end
`else
        check("k9:count", 32'(log_code.size()), 32'd1);
`endif

        // Random traffic with change pulses and back-pressure
        for (int r = 0; r < 70; r++) begin
            rk  = 16'($urandom & $urandom & $urandom);
            len = int'($urandom_range(1, 10));
            for (int j = 0; j < len; j++)
                tick(rk, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), "rand");
        end
        hold(16'h0000, 40, 1'b1, "rand_flush");

        // Asynchronous reset with events in flight
        hold(16'h0007, 10, 1'b0, "pre_rst");
        check("pre_rst:fifo_count", 32'(fifo_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst:ev_valid",   32'(ev_valid),   32'd0);
        check("arst:fifo_count", 32'(fifo_count), 32'd0);
        check("arst:stable_key", 32'(stable_key), 32'd0);
        check("arst:ev_code",    32'(ev_code),    32'd0);
        model_reset();
        key = '0;
        @(posedge clk);
        #1;
        compare_all("in_rst");
        rst_n = 1'b1;
        hold(16'h0000, 3, 1'b1, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
